// File: rtl/feature_loader_pkg.sv
// Shared types and defaults for the feature stream loader.
package feature_loader_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam int DEF_NUM_A         = 6;
    localparam int DEF_WIDTH_A       = 4;
    localparam int DEF_OUTWIDTH      = 2;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int IDX_W             = 16;

endpackage

// File: rtl/fl_settle_timer.sv
// Counts SETTLE_CYCLES clocks after a start pulse; done is high in the cycle
// before the SETTLE_CYCLES-th edge so the consumer captures on that edge.
module fl_settle_timer
    import feature_loader_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    logic [7:0] cnt_r;

    // Load on start, then count down to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (start) begin
            cnt_r <= 8'(SETTLE_CYCLES);
        end else if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == 8'd1);

endmodule

// File: rtl/feature_stream_loader.sv
// Collects NUM_A feature beats into a packed vector, waits for the classifier
// to settle, and presents the captured class. Option: FEATURE_LOADER_LAST_CHECK_EN.
module feature_stream_loader
    import feature_loader_pkg::*;
#(
    parameter int NUM_A         = DEF_NUM_A,
    parameter int WIDTH_A       = DEF_WIDTH_A,
    parameter int OUTWIDTH      = DEF_OUTWIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH_A-1:0]         s_data,
`ifdef FEATURE_LOADER_LAST_CHECK_EN
    input  logic                       s_last,
`endif
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        cls_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUTWIDTH-1:0]        m_class,
    output logic [IDX_W-1:0]           m_index,
    output logic                       err_framing
);

    localparam int CW = (NUM_A > 1) ? $clog2(NUM_A) : 1;

    state_t                     state_r;
    logic [CW-1:0]              feat_cnt_r;
    logic [NUM_A*WIDTH_A-1:0]   inp_r;
    logic                       m_valid_r;
    logic [OUTWIDTH-1:0]        m_class_r;
    logic [IDX_W-1:0]           m_index_r;

    logic accept_s;
    logic last_beat_s;
    logic start_s;
    logic done_s;
`ifdef FEATURE_LOADER_LAST_CHECK_EN
    logic err_framing_r;
    logic drop_s;
    logic miss_s;
`endif

    // Beat acceptance and framing decode.
    always_comb begin
        accept_s    = s_valid & s_ready;
        last_beat_s = (feat_cnt_r == CW'(NUM_A - 1));
`ifdef FEATURE_LOADER_LAST_CHECK_EN
        drop_s      = accept_s & s_last & ~last_beat_s;
        miss_s      = accept_s & last_beat_s & ~s_last;
`endif
        start_s     = accept_s & last_beat_s;
    end

    fl_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_s),
        .done  (done_s)
    );

    // Main FSM: packing, settle wait and result handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= LOAD;
            feat_cnt_r    <= '0;
            inp_r         <= '0;
            m_valid_r     <= 1'b0;
            m_class_r     <= '0;
            m_index_r     <= '0;
`ifdef FEATURE_LOADER_LAST_CHECK_EN
            err_framing_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        for (int k = 0; k < NUM_A; k++) begin
                            if (feat_cnt_r == CW'(k)) begin
                                inp_r[k*WIDTH_A +: WIDTH_A] <= s_data;
                            end
                        end
`ifdef FEATURE_LOADER_LAST_CHECK_EN
                        // Early s_last abandons the partial sample; stale slices remain.
                        if (drop_s) begin
                            feat_cnt_r    <= '0;
                            err_framing_r <= 1'b1;
                        end else if (last_beat_s) begin
                            feat_cnt_r <= '0;
                            state_r    <= SETTLE;
                            if (miss_s) begin
                                err_framing_r <= 1'b1;
                            end
                        end else begin
                            feat_cnt_r <= feat_cnt_r + CW'(1);
                        end
`else
                        if (last_beat_s) begin
                            feat_cnt_r <= '0;
                            state_r    <= SETTLE;
                        end else begin
                            feat_cnt_r <= feat_cnt_r + CW'(1);
                        end
`endif
                    end
                end
                SETTLE: begin
                    if (done_s) begin
                        m_class_r <= cls_in;
                        m_valid_r <= 1'b1;
                        state_r   <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid_r <= 1'b0;
                        m_index_r <= m_index_r + 16'd1;
                        state_r   <= LOAD;
                    end
                end
                default: begin
                    state_r    <= LOAD;
                    feat_cnt_r <= '0;
                    m_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = (state_r == LOAD) & rst_n;
    assign inp     = inp_r;
    assign m_valid = m_valid_r;
    assign m_class = m_class_r;
    assign m_index = m_index_r;
`ifdef FEATURE_LOADER_LAST_CHECK_EN
    assign err_framing = err_framing_r;
`else
    assign err_framing = 1'b0;
`endif

endmodule

// File: tb/tb_feature_stream_loader.sv
// Directed scoreboard bench for feature_stream_loader at default parameters.
module tb_feature_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_data;
`ifdef FEATURE_LOADER_LAST_CHECK_EN
    logic        s_last;
`endif
    logic [23:0] inp;
    logic [1:0]  cls_in;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_class;
    logic [15:0] m_index;
    logic        err_framing;

    typedef struct {
        logic [23:0] inp;
        logic [1:0]  cls;
        logic [15:0] idx;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] exp_idx;
    int          tests = 0;
    int          fails = 0;

    feature_stream_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
`ifdef FEATURE_LOADER_LAST_CHECK_EN
        .s_last      (s_last),
`endif
        .inp         (inp),
        .cls_in      (cls_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_class     (m_class),
        .m_index     (m_index),
        .err_framing (err_framing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive nb beats taken from the packed word; optionally push a result.
    task automatic send(input logic [23:0] beats, input int nb, input logic [1:0] cls,
                        input bit rnd, input int last_pos, input bit push);
        exp_t e;
        cls_in = cls;
        for (int k = 0; k < nb; k++) begin
            bit acc;
            bit done;
            int guard;
            done  = 1'b0;
            guard = 0;
            s_data = beats[k*4 +: 4];
`ifdef FEATURE_LOADER_LAST_CHECK_EN
            s_last = (k == last_pos);
`endif
            while (!done && guard < 200) begin
                s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                acc = s_valid & s_ready;
                tick();
                if (acc) done = 1'b1;
                guard++;
            end
            if (!done) chk("beat_timeout", 32'd1, 32'd0);
        end
        s_valid = 1'b0;
`ifdef FEATURE_LOADER_LAST_CHECK_EN
        s_last = 1'b0;
`endif
        if (last_pos < -1) chk("bad_arg", 32'd1, 32'd0);
        if (push) begin
            e.inp = beats;
            e.cls = cls;
            e.idx = exp_idx;
            sb_q.push_back(e);
            exp_idx = exp_idx + 16'd1;
        end
    endtask

    // Wait for result, compare against scoreboard, optionally stall, then handshake.
    task automatic take(input int exp_lat, input int hold);
        exp_t e;
        int cyc;
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            e.inp = 24'h0; e.cls = 2'd0; e.idx = 16'd0;
        end else begin
            e = sb_q.pop_front();
        end
        chk("inp", inp, e.inp);
        chk("m_class", m_class, e.cls);
        chk("m_index", m_index, e.idx);
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'b1;
            s_data  = 4'hF;
            cls_in  = ~e.cls;
            tick();
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_class", m_class, e.cls);
            chk("hold_index", m_index, e.idx);
            chk("hold_sready", s_ready, 1'b0);
            chk("hold_inp", inp, e.inp);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("post_hs_valid", m_valid, 1'b0);
        chk("post_hs_sready", s_ready, 1'b1);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 4'h0;
`ifdef FEATURE_LOADER_LAST_CHECK_EN
        s_last  = 1'b0;
`endif
        cls_in  = 2'd0;
        m_ready = 1'b0;
        exp_idx = 16'd0;

        tick(); tick();
        chk("rst_sready", s_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_sready_rel", s_ready, 1'b1);
        chk("rst_inp", inp, 24'h0);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_mindex", m_index, 16'd0);
        chk("rst_err", err_framing, 1'b0);

        // Back-to-back sample, then a stalled consumer with ignored beats.
        send(24'h654321, 6, 2'd2, 1'b0, -1, 1'b1);
        take(4, 10);
        send(24'h123456, 6, 2'd1, 1'b0, -1, 1'b1);
        take(4, 0);

        // Consumer ready in advance and random s_valid gaps.
        m_ready = 1'b1;
        send(24'h654321, 6, 2'd3, 1'b1, -1, 1'b1);
        take(4, 0);

        // Index wrap.
        force dut.m_index_r = 16'hFFFF;
        tick();
        release dut.m_index_r;
        exp_idx = 16'hFFFF;
        send(24'hABCDEF, 6, 2'd1, 1'b0, -1, 1'b1);
        take(4, 0);
        send(24'h0F0F0F, 6, 2'd2, 1'b0, -1, 1'b1);
        take(4, 0);

`ifdef FEATURE_LOADER_LAST_CHECK_EN
        send(24'h000321, 3, 2'd0, 1'b0, 2, 1'b0);
        chk("frame_err", err_framing, 1'b1);
        chk("frame_sready", s_ready, 1'b1);
        send(24'h777777, 6, 2'd3, 1'b0, 5, 1'b1);
        take(4, 0);
        chk("frame_sticky", err_framing, 1'b1);
`endif

        // Reset mid-sample discards everything.
        send(24'h000321, 3, 2'd1, 1'b0, -1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_sready", s_ready, 1'b0);
        chk("mid_rst_inp", inp, 24'h0);
        chk("mid_rst_mvalid", m_valid, 1'b0);
        chk("mid_rst_mclass", m_class, 2'd0);
        chk("mid_rst_mindex", m_index, 16'd0);
        chk("mid_rst_err", err_framing, 1'b0);
        rst_n = 1'b1;
        #1;
        exp_idx = 16'd0;
        sb_q.delete();
        send(24'h456789, 6, 2'd2, 1'b0, -1, 1'b1);
        take(4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/feature_stream_loader.md
FEATURE_STREAM_LOADER -- requirements
Module: feature_stream_loader

Interface
REQ-001 Parameter NUM_A, default 6, number of features per sample.
REQ-002 Parameter WIDTH_A, default 4, bits per feature.
REQ-003 Parameter OUTWIDTH, default 2, class result width.
REQ-004 Parameter SETTLE_CYCLES, default 4, classifier settle time in clocks; legal range 1..255.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 s_valid  in  1  feature beat valid.
REQ-008 s_ready  out  1  loader accepts feature beat.
REQ-009 s_data  in  WIDTH_A  unsigned feature value.
REQ-010 s_last  in  1  final feature of sample; present only with FEATURE_LOADER_LAST_CHECK_EN.
REQ-011 inp  out  NUM_A*WIDTH_A  packed feature vector to combinational classifier.
REQ-012 cls_in  in  OUTWIDTH  class returned by classifier.
REQ-013 m_valid  out  1  result valid.
REQ-014 m_ready  in  1  result consumer ready.
REQ-015 m_class  out  OUTWIDTH  captured class.
REQ-016 m_index  out  16  sample sequence number of current result.
REQ-017 err_framing  out  1  sticky framing error.

Function
REQ-018 FSM states LOAD, SETTLE, OUT; s_ready = 1 only in LOAD; no beat accepted elsewhere.
REQ-019 Beat accepted when s_valid & s_ready at clock edge; k-th accepted beat (k = 0..NUM_A-1) written to inp[(k+1)*WIDTH_A-1 : k*WIDTH_A]; other slices unchanged.
REQ-020 Feature counter increments per accepted beat; on beat NUM_A-1 counter returns to 0 and FSM goes LOAD->SETTLE.
REQ-021 inp is held constant through SETTLE and OUT.
REQ-022 SETTLE counts SETTLE_CYCLES clocks; on the SETTLE_CYCLES-th edge after the last beat's accept edge, cls_in is registered into m_class, m_valid set to 1, FSM -> OUT.
REQ-023 In OUT, m_class, m_index and m_valid are stable until m_valid & m_ready; on that edge m_valid -> 0, m_index increments (0xFFFF wraps to 0x0000), FSM -> LOAD.
REQ-024 m_ready held high in advance does not shorten latency; first new beat is accepted no earlier than the cycle after the result handshake.
REQ-025 s_data beats not accepted (s_ready = 0) are ignored without side effects.

Reset
REQ-026 While rst_n = 0 at an edge: FSM -> LOAD, feature counter 0, settle counter 0, inp 0, m_valid 0, m_class 0, m_index 0, err_framing 0.
REQ-027 s_ready is 0 while rst_n is low and 1 in the first cycle after rst_n goes high.
REQ-028 Reset asserted in any state, including mid-sample or with m_valid high, discards all partial data and the pending result.

Configuration
REQ-029 Macro FEATURE_LOADER_LAST_CHECK_EN defined: s_last present; s_last on beat k < NUM_A-1 sets err_framing, discards the partial sample (counter -> 0, FSM stays LOAD, inp slices not cleared); beat NUM_A-1 without s_last sets err_framing but the sample is processed normally.
REQ-030 Macro undefined: s_last port absent, framing determined by count only, err_framing tied 0.
REQ-031 err_framing clears only on reset.

Structure
REQ-032 Package feature_loader_pkg holds the state enum (LOAD, SETTLE, OUT), the parameter defaults, and the m_index width constant (16).
REQ-033 The settle counter is one sub-module, fl_settle_timer: start pulse in, done pulse out, counts SETTLE_CYCLES.
REQ-034 Remaining logic (FSM, packing, result register) stays in feature_stream_loader.

Verification
REQ-035 Defaults, beats 1,2,3,4,5,6 back-to-back with cls_in = 2 -> inp = 0x654321, m_valid rises 4 edges after the 6th accept edge, m_class = 2, m_index = 0.
REQ-036 m_ready held low 10 cycles -> m_valid, m_class and m_index stable, s_ready = 0 throughout; after handshake, second sample reports m_index = 1.
REQ-037 Preload m_index to 0xFFFF via 65535 samples (or force) -> next handshake wraps m_index to 0x0000.
REQ-038 With LAST_CHECK_EN, s_last on beat 2 -> err_framing = 1, next 6 beats 7,7,7,7,7,7 with s_last on beat 5 yield inp = 0x777777 and a normal result.
REQ-039 rst_n low for one cycle after 3 beats -> all outputs 0; following full sample 9,8,7,6,5,4 yields inp = 0x456789, m_index = 0.
REQ-040 s_valid toggled randomly over beats 1..6 -> same inp = 0x654321 as the back-to-back case.
